// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - per-source interrupt gateway with claim/complete tracking
module plic_gateway #(
    parameter  int SRC_N = 32,
    localparam int ID_W  = $clog2(SRC_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SRC_N-1:0]  i_irq,
    output logic [SRC_N-1:0]  o_pending,
    output logic [SRC_N-1:0]  o_inflight,
    input  logic              i_claim,
    input  logic [ID_W-1:0]   i_claim_id,
    output logic [ID_W-1:0]   o_claim_id,
    output logic              o_claim_vld,
    input  logic              i_complete,
    input  logic [ID_W-1:0]   i_complete_id,
    output logic [ID_W:0]     o_inflight_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_INFL = 2'd2;

    logic [1:0]       r_state [SRC_N];
    logic [ID_W-1:0]  r_claim_id;
    logic             r_claim_vld;
    logic [ID_W:0]    r_cnt;
    logic [SRC_N-1:0] w_claim_sel;
    logic [SRC_N-1:0] w_cmpl_sel;
    logic             w_claim_hit;
    logic             w_cmpl_hit;
    logic             w_unused;

    // Decoding against real slots only, so ID 0 and out-of-range IDs never select anything.
    always_comb begin
        w_claim_sel = '0;
        w_cmpl_sel  = '0;
        for (int s = 1; s < SRC_N; s++) begin
            w_claim_sel[s] = i_claim && (i_claim_id == ID_W'(s)) && (r_state[s] == ST_PEND);
            w_cmpl_sel[s]  = i_complete && (i_complete_id == ID_W'(s)) && (r_state[s] == ST_INFL);
        end
    end

    assign w_claim_hit = |w_claim_sel;
    assign w_cmpl_hit  = |w_cmpl_sel;
    assign w_unused    = i_irq[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SRC_N; s++) r_state[s] <= ST_IDLE;
            r_claim_vld <= 1'b0;
            r_claim_id  <= '0;
            r_cnt       <= '0;
        end else begin
            for (int s = 1; s < SRC_N; s++) begin
                case (r_state[s])
                    ST_IDLE: if (i_irq[s])         r_state[s] <= ST_PEND;
                    ST_PEND: if (w_claim_sel[s])   r_state[s] <= ST_INFL;
                    ST_INFL: if (w_cmpl_sel[s])    r_state[s] <= ST_IDLE;
                    default:                       r_state[s] <= ST_IDLE;
                endcase
            end
            r_claim_vld <= i_claim;
            r_claim_id  <= w_claim_hit ? i_claim_id : '0;
            r_cnt       <= r_cnt + (ID_W+1)'(w_claim_hit) - (ID_W+1)'(w_cmpl_hit);
        end
    end

    always_comb begin
        o_pending  = '0;
        o_inflight = '0;
        for (int s = 1; s < SRC_N; s++) begin
            o_pending[s]  = (r_state[s] == ST_PEND);
            o_inflight[s] = (r_state[s] == ST_INFL);
        end
    end

    assign o_claim_id     = r_claim_id;
    assign o_claim_vld    = r_claim_vld;
    assign o_inflight_cnt = r_cnt;

endmodule

// File: tb/tb_plic_gateway.sv
// tb/tb_plic_gateway.sv - directed table plus randomized model check for plic_gateway
module tb_plic_gateway;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  i_irq;
    logic [N-1:0]  o_pending, o_inflight;
    logic          i_claim, i_complete;
    logic [IW-1:0] i_claim_id, i_complete_id, o_claim_id;
    logic          o_claim_vld;
    logic [IW:0]   o_inflight_cnt;

    plic_gateway #(.SRC_N(N)) dut (
        .clk(clk), .rst_n(rst_n), .i_irq(i_irq),
        .o_pending(o_pending), .o_inflight(o_inflight),
        .i_claim(i_claim), .i_claim_id(i_claim_id),
        .o_claim_id(o_claim_id), .o_claim_vld(o_claim_vld),
        .i_complete(i_complete), .i_complete_id(i_complete_id),
        .o_inflight_cnt(o_inflight_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rstn;
        logic [N-1:0]  irq;
        logic          claim;
        logic [IW-1:0] cid;
        logic          cmpl;
        logic [IW-1:0] mid;
        logic [N-1:0]  e_pend;
        logic [N-1:0]  e_infl;
        logic          e_vld;
        logic [IW-1:0] e_id;
        int            e_cnt;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_err = 0;

    bit m_pend [N];
    bit m_infl [N];
    bit m_vld;
    int m_id;

    function automatic vec_t mk(logic rstn, logic [N-1:0] irq, logic claim, int cid,
                                logic cmpl, int mid, logic [N-1:0] ep, logic [N-1:0] ei,
                                logic ev, int eid, int ec);
        vec_t v;
        v.rstn = rstn; v.irq = irq; v.claim = claim; v.cid = IW'(cid);
        v.cmpl = cmpl; v.mid = IW'(mid); v.e_pend = ep; v.e_infl = ei;
        v.e_vld = ev; v.e_id = IW'(eid); v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending/in-flight sets updated from the gateway rules against pre-edge state.
    task automatic model_tick(input logic rstn, input logic [N-1:0] irq, input logic claim,
                              input int cid, input logic cmpl, input int mid);
        bit ok_c, ok_m;
        if (!rstn) begin
            for (int s = 0; s < N; s++) begin m_pend[s] = 0; m_infl[s] = 0; end
            m_vld = 0; m_id = 0;
            return;
        end
        ok_c = claim && cid != 0 && cid < N && m_pend[cid];
        ok_m = cmpl && mid != 0 && mid < N && m_infl[mid];
        for (int s = 1; s < N; s++)
            if (!m_pend[s] && !m_infl[s] && irq[s]) m_pend[s] = 1;
        if (ok_c) begin m_pend[cid] = 0; m_infl[cid] = 1; end
        if (ok_m) m_infl[mid] = 0;
        m_vld = claim;
        m_id  = ok_c ? cid : 0;
    endtask

    task automatic drive_cycle(input logic rstn, input logic [N-1:0] irq, input logic claim,
                               input int cid, input logic cmpl, input int mid);
        rst_n = rstn; i_irq = irq; i_claim = claim; i_claim_id = IW'(cid);
        i_complete = cmpl; i_complete_id = IW'(mid);
        @(posedge clk);
        model_tick(rstn, irq, claim, cid, cmpl, mid);
        #1;
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] mp, mi;
        int mc;
        ones = '1;
        rst_n = 0; i_irq = '0; i_claim = 0; i_claim_id = '0; i_complete = 0; i_complete_id = '0;

        tbl.push_back(mk(0, ones, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, ones, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, ones, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h20, 0, 0, 0, 0, 32'h20, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h20, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 5, 0, 0, 32'h0, 32'h20, 1, 5, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 32'h80, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80, 1, 7, 0, 0, 32'h0, 32'h80, 1, 7, 1));
        tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 32'h0, 32'h80, 0, 0, 1));
        tbl.push_back(mk(1, 32'h80, 0, 0, 1, 7, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 32'h80, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 7, 0, 0, 32'h0, 32'h80, 1, 7, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 7, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h8, 0, 0, 0, 0, 32'h8, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 32'h8, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 9, 0, 0, 32'h8, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3, 32'h8, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 0, 0, 32'h0, 32'h8, 1, 3, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h14, 0, 0, 0, 0, 32'h14, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4, 0, 0, 32'h4, 32'h10, 1, 4, 1));
        tbl.push_back(mk(1, 0, 1, 2, 1, 4, 32'h0, 32'h4, 1, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 32'h40, 32'h0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 6, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 32'h100, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8, 1, 8, 32'h0, 32'h100, 1, 8, 1));
        tbl.push_back(mk(1, 0, 1, 8, 1, 8, 32'h0, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));

        foreach (tbl[k]) begin
            drive_cycle(tbl[k].rstn, tbl[k].irq, tbl[k].claim, int'(tbl[k].cid),
                        tbl[k].cmpl, int'(tbl[k].mid));
            check($sformatf("tbl%0d pending", k), longint'(o_pending), longint'(tbl[k].e_pend));
            check($sformatf("tbl%0d inflight", k), longint'(o_inflight), longint'(tbl[k].e_infl));
            check($sformatf("tbl%0d claim_vld", k), longint'(o_claim_vld), longint'(tbl[k].e_vld));
            check($sformatf("tbl%0d claim_id", k), longint'(o_claim_id), longint'(tbl[k].e_id));
            check($sformatf("tbl%0d cnt", k), longint'(o_inflight_cnt), longint'(tbl[k].e_cnt));
        end

        for (int c = 0; c < 3000; c++) begin
            logic rr, cl, cm;
            logic [N-1:0] irq;
            rr  = ($urandom_range(0, 99) != 0);
            irq = $urandom & $urandom & $urandom;
            cl  = ($urandom_range(0, 1) == 1);
            cm  = ($urandom_range(0, 9) < 4);
            drive_cycle(rr, irq, cl, $urandom_range(0, N-1), cm, $urandom_range(0, N-1));
            mp = '0; mi = '0; mc = 0;
            for (int s = 0; s < N; s++) begin
                mp[s] = m_pend[s];
                mi[s] = m_infl[s];
                mc += int'(m_infl[s]);
            end
            check($sformatf("rnd%0d pending", c), longint'(o_pending), longint'(mp));
            check($sformatf("rnd%0d inflight", c), longint'(o_inflight), longint'(mi));
            check($sformatf("rnd%0d claim_vld", c), longint'(o_claim_vld), longint'(m_vld));
            check($sformatf("rnd%0d claim_id", c), longint'(o_claim_id), longint'(m_id));
            check($sformatf("rnd%0d cnt", c), longint'(o_inflight_cnt), longint'(mc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source interrupt gateway and claim/complete controller for the platform interrupt controller.
- Converts level-sensitive raw interrupt lines into pending bits, which feed the priority-selection logic that picks the highest-priority pending source.
- Consumes the winning ID on a claim, tracks in-flight sources until complete, and re-arms each source afterwards.
- It is the consumer end of priority selection: it takes the selected winner back and updates per-source state.

Parameters:
- SRC_N, 32, number of source slots including reserved ID 0; legal 2..1024.
- ID_W, $clog2(SRC_N), width of source ID fields; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- i_irq  input  SRC_N  raw level interrupt per source; bit 0 ignored.
- o_pending  output  SRC_N  pending bit per source, to priority selection; bit 0 always 0.
- o_inflight  output  SRC_N  claimed-not-completed bit per source; bit 0 always 0.
- i_claim  input  1  one-cycle claim-read strobe.
- i_claim_id  input  ID_W  current winner ID from priority selection (0 = none).
- o_claim_id  output  ID_W  ID returned for the claim read; valid with o_claim_vld.
- o_claim_vld  output  1  one-cycle pulse, one cycle after i_claim.
- i_complete  input  1  one-cycle complete-write strobe.
- i_complete_id  input  ID_W  ID being completed.
- o_inflight_cnt  output  ID_W+1  number of sources currently in flight.

Behaviour:
- Reset (rst_n=0 at posedge): all sources IDLE; o_pending=0, o_inflight=0, o_claim_id=0, o_claim_vld=0, o_inflight_cnt=0. Reset mid-operation drops all pending and in-flight state; an in-progress claim produces no o_claim_vld.
- Per-source FSM for sources 1..SRC_N-1, states IDLE, PENDING, INFLIGHT. Encoding: o_pending = (state==PENDING), o_inflight = (state==INFLIGHT). Source 0 is hardwired IDLE.
- IDLE -> PENDING: when i_irq[s]=1; pending is visible the cycle after irq is sampled.
- PENDING -> INFLIGHT: when i_claim=1, i_claim_id==s and the source is PENDING in that cycle.
- Deassertion of i_irq while PENDING has no effect; the source stays pending until claimed.
- INFLIGHT -> IDLE: when i_complete=1, i_complete_id==s and the source is INFLIGHT in that cycle.
- While INFLIGHT, i_irq is ignored; there is no re-pend until complete.
- After completion the source spends at least one cycle in IDLE. If i_irq is still high, it re-pends the following cycle.
- Claim response: on i_claim, the next cycle gives o_claim_vld=1 and o_claim_id = i_claim_id if that source was PENDING when sampled, else 0. Claims with ID 0, an out-of-range ID (>=SRC_N), or a non-pending source return 0 and change no state.
- Complete with ID 0, an out-of-range ID, or a non-inflight source is silently ignored.
- Simultaneous claim and complete in one cycle are both evaluated against current state:
  - Different IDs: both take effect.
  - Same ID: the claim acts only if the source is PENDING, the complete only if it is INFLIGHT; at most one applies, since the states are exclusive.
- o_inflight_cnt is registered and updates on the same edge as o_inflight: +1 on a successful claim, -1 on a successful complete, unchanged when both happen. It never wraps; its max value is SRC_N-1.
- i_claim and i_complete are single-cycle strobes. Back-to-back claims on consecutive cycles are legal, each answered one cycle later.

Test Plan:
- Reset then idle: assert rst_n=0 for 2 cycles with i_irq=all ones -> o_pending=0, o_claim_vld=0, o_inflight_cnt=0; release reset -> o_pending=0xFFFFFFFE one cycle later.
- Basic cycle, SRC_N=32: pulse i_irq[5] one cycle -> o_pending[5]=1 and holds; claim ID 5 -> next cycle o_claim_vld=1, o_claim_id=5, o_pending[5]=0, o_inflight[5]=1, cnt=1; complete ID 5 -> o_inflight[5]=0, cnt=0, no re-pend.
- Level held: i_irq[7] held high through claim and complete of ID 7 -> pending stays 0 while in flight; after complete, 1 cycle IDLE, then o_pending[7]=1 again.
- Bad claims and completes: claim ID 0, claim ID 9 (not pending), complete ID 3 (not in flight) -> o_claim_id=0 with o_claim_vld=1 for each claim, no state change, cnt unchanged.
- Simultaneous events: sources 2 and 4 both pending, claim 4 then claim 2 on back-to-back cycles, with complete 4 in the same cycle as claim 2 -> responses 4 then 2, final o_inflight=0x4, cnt=1.
- Reset mid-claim: i_claim for pending ID 6 in the same cycle as rst_n=0 -> next cycle o_claim_vld=0, all state cleared.
